// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control strobes and memory handshake between multicycle_ctrl and datapath
interface multicycle_ctrl_if;
  // status from the datapath and memory
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       MemReady;

  // control strobes and selects driven by the controller
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ResultSrc;

  modport master (
    input  Opcode, Funct3, Zero, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc
  );

  modport slave (
    output Opcode, Funct3, Zero, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for a multicycle RV32I core
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus,
  output logic              Illegal,
  output logic              BusErr,
  output logic [CNT_W-1:0]  Retired
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  // MEMADR is split by access type so the immediate select is a pure
  // function of state rather than of Opcode.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR_LD,
    S_MEMADR_ST,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  // State-only part of the control word; the MemReady/Zero dependent
  // strobes (IRWrite, PCWrite in FETCH/BRANCH) are added at the output.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       pc_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.imm_src   = 3'b010;
      end
      S_MEMADR_LD: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = 3'b000;
      end
      S_MEMADR_ST: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = 3'b001;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.result_src = 2'b01;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
        c.imm_src   = 3'b000;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.result_src = 2'b00;
      end
      S_BRANCH: begin
        c.alu_src_a  = 2'b10;
        c.alu_src_b  = 2'b00;
        c.alu_op     = 2'b01;
        c.result_src = 2'b00;
      end
      S_JAL: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.imm_src    = 3'b100;
        c.pc_write   = 1'b1;
        c.result_src = 2'b00;
      end
      S_LUI: begin
        c.imm_src    = 3'b011;
        c.reg_write  = 1'b1;
        c.result_src = 2'b11;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl_q;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] retired_cnt;
  logic             illegal_q;
  logic             buserr_q;
  logic             set_illegal;
  logic             set_buserr;
  logic             mem_state;
  logic             branch_ok;
  logic             branch_taken;
  logic             timed_out;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timed_out = (wait_cnt == TIMEOUT_CNT) && !bus.MemReady;

  // beq/bne are the only branches this core implements
  assign branch_ok    = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b001);
  assign branch_taken = ((bus.Funct3 == 3'b000) &&  bus.Zero) ||
                        ((bus.Funct3 == 3'b001) && !bus.Zero);

  // Next-state selection and trap causes
  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    set_buserr  = 1'b0;
    case (state)
      S_FETCH: begin
        if (bus.MemReady) begin
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          state_nxt  = S_TRAP;
          set_buserr = 1'b1;
        end
      end
      S_DECODE: begin
        case (bus.Opcode)
          OP_LOAD:   state_nxt = S_MEMADR_LD;
          OP_STORE:  state_nxt = S_MEMADR_ST;
          OP_RTYPE:  state_nxt = S_EXECR;
          OP_ITYPE:  state_nxt = S_EXECI;
          OP_BRANCH: state_nxt = S_BRANCH;
          OP_JAL:    state_nxt = S_JAL;
          OP_LUI:    state_nxt = S_LUI;
          default: begin
            state_nxt   = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR_LD: state_nxt = S_MEMREAD;
      S_MEMADR_ST: state_nxt = S_MEMWRITE;
      S_MEMREAD: begin
        if (bus.MemReady) begin
          state_nxt = S_MEMWB;
        end else if (timed_out) begin
          state_nxt  = S_TRAP;
          set_buserr = 1'b1;
        end
      end
      S_MEMWB: state_nxt = S_FETCH;
      S_MEMWRITE: begin
        if (bus.MemReady) begin
          state_nxt = S_FETCH;
        end else if (timed_out) begin
          state_nxt  = S_TRAP;
          set_buserr = 1'b1;
        end
      end
      S_EXECR: state_nxt = S_ALUWB;
      S_EXECI: state_nxt = S_ALUWB;
      S_ALUWB: state_nxt = S_FETCH;
      S_BRANCH: begin
        if (branch_ok) begin
          state_nxt = S_FETCH;
        end else begin
          state_nxt   = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_JAL:   state_nxt = S_ALUWB;
      S_LUI:   state_nxt = S_FETCH;
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_TRAP;
    endcase
  end

  // State register, registered control word, wait counter, retire counter and sticky traps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      ctrl_q      <= decode_ctrl(S_FETCH);
      wait_cnt    <= 8'd0;
      retired_cnt <= '0;
      illegal_q   <= 1'b0;
      buserr_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= decode_ctrl(state_nxt);
      // counts only while an access stays pending in the same memory state
      if (mem_state && !bus.MemReady && (state_nxt == state)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      // staying in FETCH while waiting is not a retirement
      if ((state != S_FETCH) && (state_nxt == S_FETCH)) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
      if (set_buserr) begin
        buserr_q <= 1'b1;
      end
    end
  end

  // Reset gates every strobe combinationally so a pending access drops at once
  assign bus.MemReq    = rst_n & ctrl_q.mem_req;
  assign bus.MemWrite  = rst_n & ctrl_q.mem_write;
  assign bus.AdrSrc    = rst_n & ctrl_q.adr_src;
  assign bus.RegWrite  = rst_n & ctrl_q.reg_write;
  assign bus.IRWrite   = rst_n & (state == S_FETCH) & bus.MemReady;
  assign bus.PCWrite   = rst_n & (ctrl_q.pc_write |
                                  ((state == S_FETCH) & bus.MemReady) |
                                  ((state == S_BRANCH) & branch_taken));
  assign bus.ImmSrc    = rst_n ? ctrl_q.imm_src    : 3'b000;
  assign bus.ALUSrcA   = rst_n ? ctrl_q.alu_src_a  : 2'b00;
  assign bus.ALUSrcB   = rst_n ? ctrl_q.alu_src_b  : 2'b00;
  assign bus.ALUOp     = rst_n ? ctrl_q.alu_op     : 2'b00;
  assign bus.ResultSrc = rst_n ? ctrl_q.result_src : 2'b00;

  assign Illegal = illegal_q;
  assign BusErr  = buserr_q;
  assign Retired = retired_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam int MT = 15;
  localparam int CW = 32;

  // instruction phases as named by the control sequence
  localparam int P_FETCH = 0, P_DECODE = 1, P_MA_LD = 2, P_MA_ST = 3, P_MREAD = 4,
                 P_MWB = 5, P_MWRITE = 6, P_EXECR = 7, P_EXECI = 8, P_ALUWB = 9,
                 P_BRANCH = 10, P_JAL = 11, P_LUI = 12, P_IDLE = 13;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_LUI = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          illegal;
  logic          bus_err;
  logic [CW-1:0] retired;
  logic [16:0]   obs;
  logic [CW-1:0] model_ret;
  int            n_checks = 0;
  int            n_fail = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .Illegal(illegal), .BusErr(bus_err), .Retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ResultSrc};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word for one cycle of a phase, straight from the output table
  function automatic logic [16:0] expv(input int ph, input logic rdy, input logic z, input logic [2:0] f3);
    logic mreq = 0, mwr = 0, adr = 0, irw = 0, pcw = 0, rw = 0;
    logic [2:0] imm = 3'b000;
    logic [1:0] a = 2'b00, b = 2'b00, op = 2'b00, rs = 2'b00;
    case (ph)
      P_FETCH:  begin mreq = 1; irw = rdy; pcw = rdy; b = 2'b10; rs = 2'b10; end
      P_DECODE: begin a = 2'b01; b = 2'b01; imm = 3'b010; end
      P_MA_LD:  begin a = 2'b10; b = 2'b01; imm = 3'b000; end
      P_MA_ST:  begin a = 2'b10; b = 2'b01; imm = 3'b001; end
      P_MREAD:  begin mreq = 1; adr = 1; end
      P_MWB:    begin rw = 1; rs = 2'b01; end
      P_MWRITE: begin mreq = 1; mwr = 1; adr = 1; end
      P_EXECR:  begin a = 2'b10; b = 2'b00; op = 2'b10; end
      P_EXECI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      P_ALUWB:  begin rw = 1; end
      P_BRANCH: begin a = 2'b10; op = 2'b01; pcw = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z); end
      P_JAL:    begin a = 2'b01; b = 2'b10; imm = 3'b100; pcw = 1; end
      P_LUI:    begin imm = 3'b011; rw = 1; rs = 2'b11; end
      default:  ;
    endcase
    return {mreq, mwr, adr, irw, pcw, rw, imm, a, b, op, rs};
  endfunction

  // One clock: drive at edge+1, check at edge+4, return at next edge+1
  task automatic step(input int ph, input logic rdy, input logic z);
    bus.MemReady = rdy;
    bus.Zero     = z;
    #3;
    check($sformatf("ctrl_ph%0d", ph), 64'(obs), 64'(expv(ph, rdy, z, bus.Funct3)));
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wait(input int ph, input int waits);
    for (int i = 0; i < waits; i++) step(ph, 1'b0, 1'($urandom));
    step(ph, 1'b1, 1'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(P_IDLE, 1'b1, 1'b1);
    step(P_IDLE, 1'b1, 1'b0);
    rst_n = 1'b1;
    model_ret = '0;
    check("rst_retired", 64'(retired), 64'(0));
    check("rst_illegal", 64'(illegal), 64'(0));
    check("rst_buserr", 64'(bus_err), 64'(0));
  endtask

  // Full instruction: fw fetch wait cycles, mw data wait cycles
  task automatic do_instr(input int kind, input logic [2:0] f3, input logic z, input int fw, input int mw);
    logic [6:0] opc;
    case (kind)
      K_LW:    opc = 7'b0000011;
      K_SW:    opc = 7'b0100011;
      K_R:     opc = 7'b0110011;
      K_I:     opc = 7'b0010011;
      K_BR:    opc = 7'b1100011;
      K_JAL:   opc = 7'b1101111;
      default: opc = 7'b0110111;
    endcase
    bus.Opcode = opc;
    bus.Funct3 = f3;
    mem_wait(P_FETCH, fw);
    step(P_DECODE, 1'($urandom), 1'($urandom));
    case (kind)
      K_LW:  begin step(P_MA_LD, 1'($urandom), 1'b0); mem_wait(P_MREAD, mw); step(P_MWB, 1'($urandom), 1'b0); end
      K_SW:  begin step(P_MA_ST, 1'($urandom), 1'b0); mem_wait(P_MWRITE, mw); end
      K_R:   begin step(P_EXECR, 1'($urandom), 1'b0); step(P_ALUWB, 1'($urandom), 1'b0); end
      K_I:   begin step(P_EXECI, 1'($urandom), 1'b0); step(P_ALUWB, 1'($urandom), 1'b0); end
      K_BR:  step(P_BRANCH, 1'($urandom), z);
      K_JAL: begin step(P_JAL, 1'($urandom), 1'b0); step(P_ALUWB, 1'($urandom), 1'b0); end
      default: step(P_LUI, 1'($urandom), 1'b0);
    endcase
    if (kind == K_BR && f3 > 3'd1) begin
      check("br_illegal", 64'(illegal), 64'(1));
      step(P_IDLE, 1'($urandom), 1'($urandom));
    end else begin
      model_ret = model_ret + 1'b1;
      check("retired", 64'(retired), 64'(model_ret));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Opcode = '0; bus.Funct3 = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // lw without waits, sw with 3 wait cycles, beq taken then bne not taken
    do_instr(K_LW, 3'b010, 1'b0, 0, 0);
    do_instr(K_SW, 3'b010, 1'b0, 0, 3);
    do_instr(K_BR, 3'b000, 1'b1, 0, 0);
    do_instr(K_BR, 3'b001, 1'b1, 0, 0);
    // MemReady exactly when the counter reaches the limit completes normally
    do_instr(K_LW, 3'b010, 1'b0, MT, MT);
    check("no_buserr_at_limit", 64'(bus_err), 64'(0));

    // random legal instruction stream
    for (int n = 0; n < 60; n++) begin
      int kind, fw, mw;
      kind = int'($urandom_range(0, 6));
      fw = ($urandom_range(0, 7) == 0) ? MT : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? MT : int'($urandom_range(0, 3));
      do_instr(kind, (kind == K_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom),
               1'($urandom), fw, mw);
    end
    check("stream_no_trap", 64'({illegal, bus_err}), 64'(0));

    // retired counter wraps
    force dut.retired_cnt = {CW{1'b1}};
    #1;
    release dut.retired_cnt;
    model_ret = {CW{1'b1}};
    do_instr(K_I, 3'b000, 1'b0, 0, 0);
    check("retired_wrap", 64'(retired), 64'(0));

    // unsupported opcode traps and stays quiet
    do_reset();
    bus.Opcode = 7'b1111111;
    step(P_FETCH, 1'b1, 1'b0);
    step(P_DECODE, 1'b0, 1'b0);
    check("illegal_set", 64'(illegal), 64'(1));
    for (int i = 0; i < 20; i++) step(P_IDLE, 1'($urandom), 1'($urandom));
    check("illegal_held", 64'(illegal), 64'(1));
    check("illegal_no_retire", 64'(retired), 64'(0));

    // unsupported branch condition traps
    do_reset();
    do_instr(K_BR, 3'b100, 1'b1, 1, 0);
    check("br_trap_no_buserr", 64'(bus_err), 64'(0));

    // fetch timeout
    do_reset();
    for (int i = 0; i < MT; i++) step(P_FETCH, 1'b0, 1'b0);
    check("buserr_before_limit", 64'(bus_err), 64'(0));
    step(P_FETCH, 1'b0, 1'b0);
    check("buserr_set", 64'(bus_err), 64'(1));
    for (int i = 0; i < 3; i++) step(P_IDLE, 1'($urandom), 1'b0);
    check("buserr_held", 64'(bus_err), 64'(1));

    // reset while a load is waiting in MEMREAD
    do_reset();
    do_instr(K_R, 3'b000, 1'b0, 0, 0);
    bus.Opcode = 7'b0000011;
    step(P_FETCH, 1'b1, 1'b0);
    step(P_DECODE, 1'b0, 1'b0);
    step(P_MA_LD, 1'b0, 1'b0);
    step(P_MREAD, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.MemReady = 1'b1;
    #3;
    check("rst_mid_outputs", 64'(obs), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ret = '0;
    check("rst_mid_retired", 64'(retired), 64'(0));
    do_instr(K_LUI, 3'b000, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
